// File: rtl/cv32e40px_xif_id_tracker.sv
// Tracks offloaded CORE-V-XIF instructions from issue through commit to result:
// allocates ids, throttles issue, exposes pending-writeback registers and flags protocol errors.
module cv32e40px_xif_id_tracker #(
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned X_DUALWRITE     = 1,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  input  logic                  x_issue_ready_i,
  output logic                  issue_allowed_o,
  output logic [X_ID_WIDTH-1:0] issue_id_o,
  input  logic [4:0]            issue_rd_i,
  input  logic                  issue_accept_i,
  input  logic                  issue_writeback_i,
  input  logic                  issue_dualwrite_i,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  input  logic                  result_valid_i,
  output logic                  result_ready_o,
  input  logic [X_ID_WIDTH-1:0] result_id_i,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic [31:0]           rd_busy_o,
  output logic                  idle_o,
  output logic                  protocol_err_o
);

  localparam int unsigned NumIds = 2 ** X_ID_WIDTH;

  typedef enum logic [1:0] {StFree, StIssued, StCommitted} entry_state_e;

  entry_state_e          r_state [NumIds];
  entry_state_e          w_state_d [NumIds];
  logic                  r_wb    [NumIds];
  logic [4:0]            r_rd    [NumIds];
  logic                  r_dual  [NumIds];
  logic [X_ID_WIDTH-1:0] r_next_id;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err;
  logic                  r_run;

  logic        w_issue_fire, w_alloc, w_dual_req, w_odd_dual;
  logic        w_commit_ok, w_kill, w_result_fire, w_result_ok, w_err_evt;
  logic [31:0] w_busy;

  assign w_issue_fire  = issue_valid_i & issue_allowed_o & x_issue_ready_i;
  assign w_alloc       = w_issue_fire & issue_accept_i;
  assign w_dual_req    = issue_dualwrite_i & (X_DUALWRITE != 0);
  assign w_odd_dual    = w_alloc & w_dual_req & issue_rd_i[0];

  // All legality checks look at the pre-edge table; a same-cycle issue never makes an id ISSUED.
  assign w_commit_ok   = commit_valid_i && (r_state[commit_id_i] == StIssued);
  assign w_kill        = w_commit_ok & commit_kill_i;
  assign w_result_fire = result_valid_i & result_ready_o;
  assign w_result_ok   = w_result_fire && (r_state[result_id_i] == StCommitted) &&
                         !(commit_valid_i && (commit_id_i == result_id_i));
  assign w_err_evt     = (commit_valid_i & ~w_commit_ok) | (w_result_fire & ~w_result_ok) |
                         w_odd_dual;

  assign issue_id_o      = r_next_id;
  assign issue_allowed_o = r_run && (r_cnt < CNT_W'(MAX_OUTSTANDING)) &&
                           (r_state[r_next_id] == StFree);
  assign result_ready_o  = r_run;
  assign outstanding_o   = r_cnt;
  assign idle_o          = (r_cnt == '0);
  assign protocol_err_o  = r_err;

  always_comb begin
    w_state_d = r_state;
    for (int i = 0; i < NumIds; i++) begin
      if (w_alloc && (r_next_id == X_ID_WIDTH'(i))) begin
        w_state_d[i] = StIssued;
      end else if (w_commit_ok && (commit_id_i == X_ID_WIDTH'(i))) begin
        w_state_d[i] = commit_kill_i ? StFree : StCommitted;
      end else if (w_result_ok && (result_id_i == X_ID_WIDTH'(i))) begin
        w_state_d[i] = StFree;
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < NumIds; i++) begin
      if ((r_state[i] != StFree) && r_wb[i]) begin
        w_busy[r_rd[i]] = 1'b1;
        if (r_dual[i]) w_busy[r_rd[i] + 5'd1] = 1'b1;
      end
    end
  end

  assign rd_busy_o = {w_busy[31:1], 1'b0};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++) begin
        r_state[i] <= StFree;
        r_wb[i]    <= 1'b0;
        r_rd[i]    <= '0;
        r_dual[i]  <= 1'b0;
      end
      r_next_id <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_run     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_alloc) begin
        r_wb[r_next_id]   <= issue_writeback_i;
        r_rd[r_next_id]   <= issue_rd_i;
        // An odd rd cannot name a register pair, so only rd itself is tracked.
        r_dual[r_next_id] <= w_dual_req & ~issue_rd_i[0];
        r_next_id         <= r_next_id + 1'b1;
      end
      r_cnt <= r_cnt + CNT_W'(w_alloc) - CNT_W'(w_kill) - CNT_W'(w_result_ok);
      r_err <= r_err | w_err_evt;
      r_run <= 1'b1;
    end
  end

endmodule
